// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: shares the WB write port between the in-order pipeline
// and a buffered multi-cycle (MUL/DIV) result stream, with starvation stall and stale-result squash.
module wb_port_arbiter #(
  parameter int DATA_WIDTH   = 16,
  parameter int REG_WIDTH    = 4,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_we_i,
  input  logic [REG_WIDTH-1:0]  pipe_addr_i,
  input  logic [DATA_WIDTH-1:0] pipe_data_i,
  input  logic                  mc_valid_i,
  input  logic [REG_WIDTH-1:0]  mc_addr_i,
  input  logic [DATA_WIDTH-1:0] mc_data_i,
  output logic                  mc_ready_o,
  output logic                  rf_we_o,
  output logic [REG_WIDTH-1:0]  rf_addr_o,
  output logic [DATA_WIDTH-1:0] rf_data_o,
  output logic                  stall_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  logic [FIFO_DEPTH-1:0] entryVld;
  logic [REG_WIDTH-1:0]  entryAddr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] entryData [FIFO_DEPTH];
  logic [PTR_W-1:0]      headPtr, tailPtr;
  logic [CNT_W-1:0]      count;
  logic [STV_W-1:0]      starveCnt;

  logic headLive, accept, grantHead, grantPipe, pop;

  // Every handshake term is gated by rst so nothing escapes during the reset cycle.
  assign mc_ready_o = !rst && (count < CNT_W'(FIFO_DEPTH));
  assign accept     = mc_valid_i && mc_ready_o;
  assign headLive   = (count != '0) && entryVld[headPtr];
  assign stall_o    = !rst && headLive && (starveCnt == STV_W'(STARVE_LIMIT));
  assign grantHead  = !rst && (stall_o || (!pipe_we_i && headLive));
  assign grantPipe  = !rst && !stall_o && pipe_we_i;
  assign pop        = grantHead || (!rst && (count != '0) && !entryVld[headPtr]);

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    rf_we_o   = 1'b0;
    rf_addr_o = '0;
    rf_data_o = '0;
    if (grantHead) begin
      rf_we_o   = 1'b1;
      rf_addr_o = entryAddr[headPtr];
      rf_data_o = entryData[headPtr];
    end else if (grantPipe) begin
      rf_we_o   = 1'b1;
      rf_addr_o = pipe_addr_i;
      rf_data_o = pipe_data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; later assignments to the same
  // entryVld bit win, so an enqueue overrides the squash loop on the tail slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      entryVld  <= '0;
      headPtr   <= '0;
      tailPtr   <= '0;
      count     <= '0;
      starveCnt <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (grantPipe && entryVld[i] && (entryAddr[i] == pipe_addr_i)) begin
          entryVld[i] <= 1'b0;
        end
      end
      if (accept) begin
        entryVld[tailPtr] <= !(grantPipe && (mc_addr_i == pipe_addr_i));
        tailPtr           <= tailPtr + 1'b1;
      end
      if (pop) begin
        headPtr <= headPtr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (headLive && grantPipe) begin
        if (starveCnt != STV_W'(STARVE_LIMIT)) begin
          starveCnt <= starveCnt + 1'b1;
        end
      end else begin
        starveCnt <= '0;
      end
    end
  end

  // NOTE: payload storage has no reset; validity is carried by entryVld and count alone.
  always_ff @(posedge clk) begin
    if (accept) begin
      entryAddr[tailPtr] <= mc_addr_i;
      entryData[tailPtr] <= mc_data_i;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench: a queue-based model predicts every output each cycle; directed
// scenarios add hand-computed literal expectations, followed by randomized traffic.
module tb_wb_port_arbiter;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          pipe_we_i;
  logic [AW-1:0] pipe_addr_i;
  logic [DW-1:0] pipe_data_i;
  logic          mc_valid_i;
  logic [AW-1:0] mc_addr_i;
  logic [DW-1:0] mc_data_i;
  logic          mc_ready_o;
  logic          rf_we_o;
  logic [AW-1:0] rf_addr_o;
  logic [DW-1:0] rf_data_o;
  logic          stall_o;

  always #5 clk = ~clk;

  wb_port_arbiter #(
    .DATA_WIDTH  (DW),
    .REG_WIDTH   (AW),
    .FIFO_DEPTH  (DEPTH),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pipe_we_i  (pipe_we_i),
    .pipe_addr_i(pipe_addr_i),
    .pipe_data_i(pipe_data_i),
    .mc_valid_i (mc_valid_i),
    .mc_addr_i  (mc_addr_i),
    .mc_data_i  (mc_data_i),
    .mc_ready_o (mc_ready_o),
    .rf_we_o    (rf_we_o),
    .rf_addr_o  (rf_addr_o),
    .rf_data_o  (rf_data_o),
    .stall_o    (stall_o)
  );

  typedef struct {
    logic          vld;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  entry_t mq[$];
  int     starve;
  int     nChecks = 0;
  int     nFails  = 0;

  logic          eWe, eStall, eReady, live, headGrant, pipeGrant;
  logic [AW-1:0] eAddr;
  logic [DW-1:0] eData;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then predict and compare every output.
  task automatic apply(input logic r, input logic pw, input logic [AW-1:0] pa,
                       input logic [DW-1:0] pd, input logic mv, input logic [AW-1:0] ma,
                       input logic [DW-1:0] md);
    rst = r; pipe_we_i = pw; pipe_addr_i = pa; pipe_data_i = pd;
    mc_valid_i = mv; mc_addr_i = ma; mc_data_i = md;
    #1;
    eWe = 0; eAddr = '0; eData = '0; eStall = 0; eReady = 0;
    live = 0; headGrant = 0; pipeGrant = 0;
    if (!r) begin
      eReady = (mq.size() < DEPTH);
      if (mq.size() > 0) live = mq[0].vld;
      eStall = live && (starve == LIMIT);
      if (eStall || (!pw && live)) begin
        headGrant = 1; eWe = 1; eAddr = mq[0].addr; eData = mq[0].data;
      end else if (pw) begin
        pipeGrant = 1; eWe = 1; eAddr = pa; eData = pd;
      end
    end
    check("model_we",    32'(rf_we_o),    32'(eWe));
    check("model_addr",  32'(rf_addr_o),  32'(eAddr));
    check("model_data",  32'(rf_data_o),  32'(eData));
    check("model_stall", 32'(stall_o),    32'(eStall));
    check("model_ready", 32'(mc_ready_o), 32'(eReady));
  endtask

  // Advance the model across the clock edge using the inputs still being driven.
  task automatic clock();
    logic doPop;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      starve = 0;
    end else begin
      doPop = headGrant || (mq.size() > 0 && !mq[0].vld);
      if (live && pipeGrant) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
      else starve = 0;
      if (pipeGrant) foreach (mq[i]) if (mq[i].addr == pipe_addr_i) mq[i].vld = 1'b0;
      if (doPop) void'(mq.pop_front());
      if (mc_valid_i && eReady)
        mq.push_back('{vld: !(pipeGrant && mc_addr_i == pipe_addr_i), addr: mc_addr_i, data: mc_data_i});
    end
    @(negedge clk);
  endtask

  task automatic pin(input string name, input logic we, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic st, input logic rdy);
    check({name, "_we"},    32'(rf_we_o),    32'(we));
    check({name, "_addr"},  32'(rf_addr_o),  32'(a));
    check({name, "_data"},  32'(rf_data_o),  32'(d));
    check({name, "_stall"}, 32'(stall_o),    32'(st));
    check({name, "_ready"}, 32'(mc_ready_o), 32'(rdy));
  endtask

  task automatic idle();
    apply(0, 0, '0, '0, 0, '0, '0);
  endtask

  initial begin
    starve = 0;
    @(negedge clk);

    // Reset cycle with active requests: everything quiet.
    apply(1, 1, 4'd2, 16'h5555, 1, 4'd3, 16'h3333);
    pin("rst", 0, 0, 0, 0, 0);
    clock();

    // Idle pipe: R3 accepted, written the next cycle.
    apply(0, 0, '0, '0, 1, 4'd3, 16'h1234);
    pin("t1_acc", 0, 0, 0, 0, 1);
    clock();
    idle();
    pin("t1_wr", 1, 4'd3, 16'h1234, 0, 1);
    clock();
    idle();
    pin("t1_empty", 0, 0, 0, 0, 1);
    clock();

    // Pipe busy: R5 starves for four cycles, then a one-cycle stall retires it.
    apply(0, 1, 4'd1, 16'h0100, 1, 4'd5, 16'hBEEF);
    pin("t2_acc", 1, 4'd1, 16'h0100, 0, 1);
    clock();
    for (int k = 1; k <= 4; k++) begin
      apply(0, 1, 4'd1, 16'(16'h0100 + k), 0, '0, '0);
      pin("t2_pipe", 1, 4'd1, 16'(16'h0100 + k), 0, 1);
      clock();
    end
    apply(0, 1, 4'd1, 16'h0105, 0, '0, '0);
    pin("t2_stall", 1, 4'd5, 16'hBEEF, 1, 1);
    clock();
    apply(0, 1, 4'd1, 16'h0105, 0, '0, '0);
    pin("t2_resume", 1, 4'd1, 16'h0105, 0, 1);
    clock();

    // Back-to-back accepts fill the buffer; third result held off; drain in order.
    apply(0, 1, 4'd1, 16'h0200, 1, 4'd2, 16'hAAAA);
    clock();
    apply(0, 1, 4'd1, 16'h0201, 1, 4'd4, 16'hBBBB);
    clock();
    apply(0, 0, '0, '0, 1, 4'd9, 16'h9999);
    pin("t3_full", 1, 4'd2, 16'hAAAA, 0, 0);
    clock();
    idle();
    pin("t3_second", 1, 4'd4, 16'hBBBB, 0, 1);
    clock();
    idle();
    pin("t3_empty", 0, 0, 0, 0, 1);
    clock();

    // Younger pipe write squashes buffered R7; the stale entry drops silently.
    apply(0, 1, 4'd1, 16'h0011, 1, 4'd7, 16'h1111);
    clock();
    apply(0, 1, 4'd7, 16'h2222, 0, '0, '0);
    pin("t4_pipe", 1, 4'd7, 16'h2222, 0, 1);
    clock();
    idle();
    pin("t4_drop", 0, 0, 0, 0, 1);
    clock();
    idle();
    pin("t4_quiet", 0, 0, 0, 0, 1);
    clock();

    // Same-cycle pipe and mc write to R6: pipe wins, buffered copy never written.
    apply(0, 1, 4'd6, 16'h0006, 1, 4'd6, 16'h0600);
    pin("t5_pipe", 1, 4'd6, 16'h0006, 0, 1);
    clock();
    idle();
    pin("t5_drop", 0, 0, 0, 0, 1);
    clock();
    idle();
    pin("t5_quiet", 0, 0, 0, 0, 1);
    clock();

    // Reset with two buffered entries discards them.
    apply(0, 1, 4'd1, 16'h0300, 1, 4'd8, 16'h0808);
    clock();
    apply(0, 1, 4'd1, 16'h0301, 1, 4'd9, 16'h0909);
    clock();
    apply(1, 1, 4'd1, 16'h0302, 1, 4'd10, 16'h0A0A);
    pin("t6_rst", 0, 0, 0, 0, 0);
    clock();
    idle();
    pin("t6_after", 0, 0, 0, 0, 1);
    clock();
    idle();
    pin("t6_quiet", 0, 0, 0, 0, 1);
    clock();

    // Randomized traffic over a narrow address range to provoke squashes and stalls.
    for (int n = 0; n < 3000; n++) begin
      apply(($urandom_range(0, 99) == 0),
            1'($urandom_range(0, 99) < 70),
            AW'($urandom_range(0, 3)),
            DW'($urandom),
            1'($urandom_range(0, 1)),
            AW'($urandom_range(0, 3)),
            DW'($urandom));
      clock();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
